// File: rtl/signal_pkg.sv
// signal_pkg
// Shared types and constants for the filter-to-detector sample path.
// Holds the detector state encoding and the common sample type so the FIR
// stage, the beat detector and the downstream rate logic agree on widths.
// No ports (package).
package signal_pkg;

    // Width of one filtered sample on the filter/detector interface.
    localparam int SAMPLE_W = 10;

    // One filtered sample, unsigned.
    typedef logic [SAMPLE_W-1:0] sample_t;

    // Beat detector states:
    //   ARM  - waiting for the signal to go low before trusting any crossing
    //   LOW  - below the band, looking for a rising crossing
    //   HIGH - inside a pulse, tracking its peak
    typedef enum logic [1:0] {
        ARM,
        LOW,
        HIGH
    } beat_state_t;

endpackage : signal_pkg

// File: rtl/sat_counter.sv
// sat_counter
// CNT_W-bit up counter that sticks at all-ones instead of wrapping.
// A load request restarts the count at 1; it takes priority over the increment.
// The saturation flag is registered together with the count so it always
// describes the value currently held.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset (count and flag to 0)
//   en_i     in   advance the counter by one (if not saturated)
//   load1_i  in   restart the counter at 1
//   count_o  out  current count
//   sat_o    out  high while count_o is all-ones
module sat_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load1_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             sat_q;

    // Next count: a load always wins, otherwise step by one until the
    // counter reaches all-ones and then hold there.
    always_comb begin
        count_d = count_q;
        if (load1_i) begin
            count_d = CNT_W'(1);
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count and saturation flag registers; the flag is decoded from the
    // next count so it lines up with the value it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= (count_d == CNT_MAX);
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule : sat_counter

// File: rtl/beat_detector.sv
// beat_detector
// Pulse beat detector fed by the FIR low-pass output. A hysteresis comparator
// around thr finds rising crossings; a refractory window rejects crossings
// that come too soon after the previous one. Each accepted beat reports the
// number of valid samples since the previous accepted (or reference)
// crossing and the peak amplitude of the pulse before it.
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   sample_valid   in   qualifies sample; only these cycles advance anything
//   sample         in   filtered sample, unsigned
//   thr            in   detection threshold, read on every valid sample
//   beat_valid     out  one-cycle pulse per accepted beat
//   beat_interval  out  samples since the previous accepted crossing
//   beat_peak      out  peak of the most recent completed pulse
//   in_pulse       out  high while the detector is in HIGH
//   timeout        out  high while the interval counter is saturated
module beat_detector
    import signal_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int CNT_W        = 12,
    parameter int HYST         = 16,
    parameter int MIN_INTERVAL = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thr,
    output logic              beat_valid,
    output logic [CNT_W-1:0]  beat_interval,
    output logic [DATA_W-1:0] beat_peak,
    output logic              in_pulse,
    output logic              timeout
);

    localparam logic [DATA_W:0]  SAMPLE_MAX_W = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W:0]  HYST_W       = (DATA_W+1)'(HYST);
    localparam logic [CNT_W-1:0] MIN_CNT      = CNT_W'(MIN_INTERVAL);

    beat_state_t       state_q;
    logic              haveRef_q;
    logic [DATA_W-1:0] peakAcc_q;
    logic [DATA_W-1:0] lastPeak_q;
    logic              beatValid_q;
    logic [CNT_W-1:0]  beatInterval_q;
    logic [DATA_W-1:0] beatPeak_q;
    logic              inPulse_q;

    logic [DATA_W:0]   thrSum;
    logic [DATA_W:0]   thrDiff;
    logic [DATA_W-1:0] thrHi;
    logic [DATA_W-1:0] thrLo;
    logic              risingCross;
    logic              fallingCross;
    logic              refractory;
    logic              newRef;
    logic              crossing;
    logic              beatAccept;
    logic              cntLoad;
    logic [CNT_W-1:0]  count;
    logic              countSat;

    // Hysteresis band around thr, worked out one bit wider so that the
    // band edges clamp to the sample range instead of wrapping around.
    always_comb begin
        thrSum  = {1'b0, thr} + HYST_W;
        thrDiff = {1'b0, thr} - HYST_W;
        thrHi   = (thrSum > SAMPLE_MAX_W) ? {DATA_W{1'b1}} : thrSum[DATA_W-1:0];
        thrLo   = ({1'b0, thr} >= HYST_W) ? thrDiff[DATA_W-1:0] : '0;
    end

    // Crossing classification for the current sample. A crossing inside the
    // refractory window is ignored for timing (the counter keeps running);
    // a crossing with no reference yet, or after the counter gave up at
    // saturation, only restarts timing; anything else is a real beat.
    always_comb begin
        risingCross  = (sample >= thrHi);
        fallingCross = (sample <= thrLo);
        refractory   = haveRef_q && (count < MIN_CNT);
        newRef       = !haveRef_q || countSat;
        crossing     = sample_valid && (state_q == LOW) && risingCross;
        beatAccept   = crossing && !refractory && !newRef;
        cntLoad      = crossing && !refractory;
    end

    // Interval counter: counts every valid sample, restarts at 1 on each
    // crossing that starts a new interval.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_interval_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (sample_valid),
        .load1_i (cntLoad),
        .count_o (count),
        .sat_o   (countSat)
    );

    // Detector FSM with registered outputs. beat_peak simply follows the
    // last completed pulse peak one cycle later, so at a beat it shows the
    // pulse before the one just starting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ARM;
            haveRef_q      <= 1'b0;
            peakAcc_q      <= '0;
            lastPeak_q     <= '0;
            beatValid_q    <= 1'b0;
            beatInterval_q <= '0;
            beatPeak_q     <= '0;
            inPulse_q      <= 1'b0;
        end else begin
            beatValid_q <= 1'b0;
            beatPeak_q  <= lastPeak_q;
            if (sample_valid) begin
                case (state_q)
                    ARM: begin
                        if (fallingCross) begin
                            state_q <= LOW;
                        end
                    end
                    LOW: begin
                        if (risingCross) begin
                            state_q   <= HIGH;
                            inPulse_q <= 1'b1;
                            peakAcc_q <= sample;
                            if (!refractory && newRef) begin
                                haveRef_q <= 1'b1;
                            end
                            if (beatAccept) begin
                                beatValid_q    <= 1'b1;
                                beatInterval_q <= count;
                            end
                        end
                    end
                    HIGH: begin
                        if (fallingCross) begin
                            state_q    <= LOW;
                            inPulse_q  <= 1'b0;
                            lastPeak_q <= peakAcc_q;
                        end else if (sample > peakAcc_q) begin
                            peakAcc_q <= sample;
                        end
                    end
                    default: begin
                        state_q   <= ARM;
                        inPulse_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign beat_valid    = beatValid_q;
    assign beat_interval = beatInterval_q;
    assign beat_peak     = beatPeak_q;
    assign in_pulse      = inPulse_q;
    assign timeout       = countSat;

endmodule : beat_detector

// File: tb/tb_beat_detector.sv
// tb_beat_detector
// Directed-vector bench for beat_detector. Expected beats are queued by the
// stimulus and popped by a monitor whenever beat_valid is seen.
module tb_beat_detector;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 12;

    typedef struct {
        int interval;
        int peak;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] thr;
    logic              beat_valid;
    logic [CNT_W-1:0]  beat_interval;
    logic [DATA_W-1:0] beat_peak;
    logic              in_pulse;
    logic              timeout;

    beat_t expQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;
    logic  sawPulse    = 1'b0;

    always #5 clk = ~clk;

    beat_detector dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .thr           (thr),
        .beat_valid    (beat_valid),
        .beat_interval (beat_interval),
        .beat_peak     (beat_peak),
        .in_pulse      (in_pulse),
        .timeout       (timeout)
    );

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one valid sample after 'gap' idle cycles (inputs change on the
    // falling edge, so the DUT sees them cleanly on the next rising edge).
    task automatic applyStimulus(input logic [DATA_W-1:0] s, input int gap);
        repeat (gap) begin
            @(negedge clk);
            sample_valid = 1'b0;
            sample       = DATA_W'($urandom);
        end
        @(negedge clk);
        sample_valid = 1'b1;
        sample       = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset        = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expectDrained(input string name);
        idle(4);
        checkOutput(name, expQ.size(), 0);
    endtask

    task automatic pushBeat(input int interval, input int peak);
        beat_t b;
        b.interval = interval;
        b.peak     = peak;
        expQ.push_back(b);
    endtask

    // Monitor: every beat the DUT presents is matched against the oldest
    // expected beat; also remembers whether in_pulse was ever seen high.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (in_pulse === 1'b1) begin
            sawPulse = 1'b1;
        end
        if (beat_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_beat: got interval %0d peak %0d, expected no beat",
                         beat_interval, beat_peak);
            end else begin
                e = expQ.pop_front();
                checkOutput("beat_interval", int'(beat_interval), e.interval);
                checkOutput("beat_peak", int'(beat_peak), e.peak);
            end
        end
    end

    // Run-away guard.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of run, expected $finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        thr          = 10'd512;
        idle(2);

        // Reset state.
        doReset();
        checkOutput("reset_beat_valid", beat_valid, 0);
        checkOutput("reset_beat_interval", int'(beat_interval), 0);
        checkOutput("reset_beat_peak", int'(beat_peak), 0);
        checkOutput("reset_in_pulse", in_pulse, 0);
        checkOutput("reset_timeout", timeout, 0);

        // Reference at index 5 (peak 700), beat at index 105 with gaps.
        for (int i = 0; i < 5; i++) applyStimulus(10'd400, $urandom_range(0, 2));
        applyStimulus(10'd600, $urandom_range(0, 2));
        applyStimulus(10'd700, $urandom_range(0, 2));
        idle(1);
        checkOutput("s1_in_pulse_high", in_pulse, 1);
        for (int i = 7; i < 105; i++) applyStimulus(10'd400, $urandom_range(0, 2));
        pushBeat(100, 700);
        applyStimulus(10'd600, $urandom_range(0, 2));
        applyStimulus(10'd400, $urandom_range(0, 2));
        expectDrained("s1_beats_seen");

        // Refractory: crossings at 0, 20, 100 -> one beat at 100.
        doReset();
        applyStimulus(10'd400, 0);
        applyStimulus(10'd600, 0);
        for (int i = 1; i < 20; i++) applyStimulus(10'd400, 0);
        applyStimulus(10'd600, 0);
        for (int i = 21; i < 100; i++) applyStimulus(10'd400, $urandom_range(0, 1));
        pushBeat(100, 600);
        applyStimulus(10'd600, 0);
        applyStimulus(10'd400, 0);
        expectDrained("s2_beats_seen");

        // Hysteresis: 500/525 never leaves the band.
        doReset();
        applyStimulus(10'd400, 0);
        idle(1);
        sawPulse = 1'b0;
        for (int i = 0; i < 200; i++) applyStimulus((i % 2 == 0) ? 10'd500 : 10'd525, $urandom_range(0, 1));
        idle(2);
        checkOutput("s3_no_pulse", sawPulse, 0);
        expectDrained("s3_no_beats");

        // Timeout: saturation, then a saturated crossing, then a beat of 80.
        doReset();
        applyStimulus(10'd400, 0);
        applyStimulus(10'd600, 0);
        for (int i = 1; i < 4094; i++) applyStimulus(10'd400, 0);
        idle(1);
        checkOutput("s4_timeout_before_sat", timeout, 0);
        applyStimulus(10'd400, 0);
        idle(1);
        checkOutput("s4_timeout_at_sat", timeout, 1);
        for (int i = 4095; i < 4201; i++) applyStimulus(10'd400, 0);
        idle(1);
        checkOutput("s4_timeout_held", timeout, 1);
        applyStimulus(10'd600, 0);
        idle(1);
        checkOutput("s4_timeout_cleared", timeout, 0);
        checkOutput("s4_in_pulse", in_pulse, 1);
        for (int i = 4202; i < 4281; i++) applyStimulus(10'd400, 0);
        pushBeat(80, 600);
        applyStimulus(10'd600, 0);
        applyStimulus(10'd400, 0);
        expectDrained("s4_beats_seen");

        // Reset while in HIGH, then re-arm and two fresh crossings.
        doReset();
        applyStimulus(10'd400, 0);
        applyStimulus(10'd600, 0);
        for (int i = 1; i < 51; i++) applyStimulus(10'd400, 0);
        pushBeat(51, 600);
        applyStimulus(10'd700, 0);
        idle(1);
        checkOutput("s5_in_pulse_before_reset", in_pulse, 1);
        idle(2);
        checkOutput("s5_first_beat_seen", expQ.size(), 0);
        @(negedge clk);
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample       = 10'd700;
        @(negedge clk);
        reset        = 1'b0;
        sample_valid = 1'b0;
        checkOutput("s5_rst_in_pulse", in_pulse, 0);
        checkOutput("s5_rst_beat_valid", beat_valid, 0);
        checkOutput("s5_rst_beat_peak", int'(beat_peak), 0);
        checkOutput("s5_rst_beat_interval", int'(beat_interval), 0);
        checkOutput("s5_rst_timeout", timeout, 0);
        for (int i = 0; i < 5; i++) applyStimulus(10'd700, 0);
        idle(1);
        checkOutput("s5_armed_no_pulse", in_pulse, 0);
        applyStimulus(10'd400, 0);
        applyStimulus(10'd600, 0);
        for (int i = 0; i < 45; i++) applyStimulus(10'd400, 0);
        pushBeat(46, 600);
        applyStimulus(10'd600, 0);
        applyStimulus(10'd400, 0);
        expectDrained("s5_beats_seen");

        // Threshold clamping at both ends of the sample range.
        doReset();
        thr = 10'd1020;
        applyStimulus(10'd0, 0);
        applyStimulus(10'd1022, 0);
        idle(1);
        checkOutput("s6_below_clamped_hi", in_pulse, 0);
        applyStimulus(10'd1023, 0);
        idle(1);
        checkOutput("s6_cross_at_1023", in_pulse, 1);
        thr = 10'd5;
        applyStimulus(10'd1, 0);
        idle(1);
        checkOutput("s6_above_clamped_lo", in_pulse, 1);
        applyStimulus(10'd0, 0);
        idle(1);
        checkOutput("s6_release_at_0", in_pulse, 0);
        expectDrained("s6_no_beats");

        idle(2);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_beat_detector
